// File: rtl/demux_2bit_deser.sv
// 2-bit slice deserializer: one slice per in_valid/in_ready handshake, assembled into a 2*SLICES-bit word.
// Optional DEMUX_LAST_SLICE_EN adds in_last to end a word early (unfilled slots stay 0).

module demux_2bit_deser_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we_i,
  input  logic       clr_i,
  input  logic [1:0] din_i,
  output logic [1:0] dout_o
);
  logic [1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr_i)     slot_d = 2'b00;
    else if (we_i) slot_d = din_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) slot_q <= 2'b00;
    else        slot_q <= slot_d;
  end

  assign dout_o = slot_q;
endmodule

module demux_2bit_deser #(
  parameter int SLICES    = 4,
  parameter int CNT_W     = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            in_slice,
  input  logic                  in_valid,
`ifdef DEMUX_LAST_SLICE_EN
  input  logic                  in_last,
`endif
  output logic                  in_ready,
  output logic [2*SLICES-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      slice_cnt
);
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SLICES - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        slot_idx;
  logic                    accept, word_end, clr;
  logic [SLICES-1:0]       slot_we;
  logic [SLICES-1:0][1:0]  data_w;

  assign in_ready = rst_n & (state_q == COLLECT);
  assign accept   = in_valid & in_ready;
  assign slot_idx = (MSB_FIRST != 0) ? (LAST_IDX - cnt_q) : cnt_q;

`ifdef DEMUX_LAST_SLICE_EN
  assign word_end = (cnt_q == LAST_IDX) | in_last;
`else
  assign word_end = (cnt_q == LAST_IDX);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    case (state_q)
      COLLECT: begin
        if (accept) begin
          if (word_end) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      HOLD: begin
        // consume costs one bubble cycle: in_ready stays low this cycle
        if (out_ready) begin
          state_d = COLLECT;
          clr     = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < SLICES; i++) begin : g_slot
    assign slot_we[i] = accept & (slot_idx == CNT_W'(i));
    demux_2bit_deser_slot u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .we_i   (slot_we[i]),
      .clr_i  (clr),
      .din_i  (in_slice),
      .dout_o (data_w[i])
    );
  end

  assign out_data  = data_w;
  assign out_valid = (state_q == HOLD);
  assign slice_cnt = cnt_q;
endmodule

// File: tb/tb_demux_2bit_deser.sv
// Directed bench: LSB-first (a) and MSB-first (b) instances share one stimulus stream.

module tb_demux_2bit_deser;
  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready, in_last;
  logic [1:0] in_slice;
  logic       rdy_a, rdy_b, vld_a, vld_b;
  logic [7:0] dat_a, dat_b;
  logic [1:0] cnt_a, cnt_b;
  int         n_tot = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  demux_2bit_deser #(.SLICES(4), .CNT_W(2), .MSB_FIRST(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_slice(in_slice), .in_valid(in_valid),
`ifdef DEMUX_LAST_SLICE_EN
    .in_last(in_last),
`endif
    .in_ready(rdy_a), .out_data(dat_a), .out_valid(vld_a),
    .out_ready(out_ready), .slice_cnt(cnt_a)
  );

  demux_2bit_deser #(.SLICES(4), .CNT_W(2), .MSB_FIRST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_slice(in_slice), .in_valid(in_valid),
`ifdef DEMUX_LAST_SLICE_EN
    .in_last(in_last),
`endif
    .in_ready(rdy_b), .out_data(dat_b), .out_valid(vld_b),
    .out_ready(out_ready), .slice_cnt(cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic last);
    in_valid = 1'b1; in_slice = s; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_slice = 2'b00; out_ready = 1'b0; in_last = 1'b0;
    #1;
    chk("rdy_in_rst_pre", {rdy_a, rdy_b}, 2'b00);
    step();
    chk("rst_cnt", {cnt_a, cnt_b}, 4'h0);
    chk("rst_dat", {dat_a, dat_b}, 16'h0000);
    chk("rst_vld", {vld_a, vld_b}, 2'b00);
    chk("rdy_in_rst", {rdy_a, rdy_b}, 2'b00);
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", {rdy_a, rdy_b}, 2'b11);

    // word 1: 01,10,11,00 back to back
    send(2'b01, 1'b0);
    chk("w1_cnt1", {cnt_a, cnt_b}, {2'd1, 2'd1});
    send(2'b10, 1'b0);
    send(2'b11, 1'b0);
    chk("w1_cnt3", {cnt_a, cnt_b}, {2'd3, 2'd3});
    chk("w1_vld_pre", {vld_a, vld_b}, 2'b00);
    send(2'b00, 1'b0);
    chk("w1_vld", {vld_a, vld_b}, 2'b11);
    chk("w1_dat_lsb", dat_a, 8'h39);
    chk("w1_dat_msb", dat_b, 8'h6C);
    chk("w1_cnt_wrap", {cnt_a, cnt_b}, 4'h0);

    // hold with pending input and no out_ready
    in_valid = 1'b1; in_slice = 2'b10;
    for (int i = 0; i < 3; i++) begin
      chk("hold_rdy", {rdy_a, rdy_b}, 2'b00);
      step();
      chk("hold_dat", {dat_a, dat_b}, 16'h396C);
      chk("hold_vld", {vld_a, vld_b}, 2'b11);
      chk("hold_cnt", {cnt_a, cnt_b}, 4'h0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("cons_vld", {vld_a, vld_b}, 2'b00);
    chk("cons_dat", {dat_a, dat_b}, 16'h0000);
    chk("cons_cnt", {cnt_a, cnt_b}, 4'h0);
    chk("cons_rdy", {rdy_a, rdy_b}, 2'b11);

    // word 2: 11 x4 with gaps 0,2,5; first 11 is accepted right after the bubble
    in_slice = 2'b11;
    step();
    chk("gap_cnt1", {cnt_a, cnt_b}, {2'd1, 2'd1});
    send(2'b11, 1'b0);
    chk("gap_cnt2", {cnt_a, cnt_b}, {2'd2, 2'd2});
    in_slice = 2'b00;
    repeat (2) step();
    chk("gap2_cnt", {cnt_a, cnt_b}, {2'd2, 2'd2});
    send(2'b11, 1'b0);
    chk("gap_cnt3", {cnt_a, cnt_b}, {2'd3, 2'd3});
    repeat (5) step();
    chk("gap5_cnt", {cnt_a, cnt_b}, {2'd3, 2'd3});
    chk("gap5_vld", {vld_a, vld_b}, 2'b00);
    send(2'b11, 1'b0);
    chk("w2_vld", {vld_a, vld_b}, 2'b11);
    chk("w2_dat", {dat_a, dat_b}, 16'hFFFF);
    chk("w2_cnt", {cnt_a, cnt_b}, 4'h0);
    consume();
    chk("w2_cons_vld", {vld_a, vld_b}, 2'b00);

    // partial word then reset
    send(2'b01, 1'b0);
    send(2'b10, 1'b0);
    chk("part_dat_lsb", dat_a, 8'h09);
    chk("part_dat_msb", dat_b, 8'h60);
    chk("part_cnt", {cnt_a, cnt_b}, {2'd2, 2'd2});
    rst_n = 1'b0;
    in_valid = 1'b1; in_slice = 2'b11;
    #1;
    chk("mid_rst_rdy", {rdy_a, rdy_b}, 2'b00);
    step();
    in_valid = 1'b0;
    rst_n = 1'b1;
    chk("mid_rst_cnt", {cnt_a, cnt_b}, 4'h0);
    chk("mid_rst_dat", {dat_a, dat_b}, 16'h0000);
    send(2'b00, 1'b0);
    send(2'b00, 1'b0);
    send(2'b00, 1'b0);
    send(2'b11, 1'b0);
    chk("w3_vld", {vld_a, vld_b}, 2'b11);
    chk("w3_dat_lsb", dat_a, 8'hC0);
    chk("w3_dat_msb", dat_b, 8'h03);
    consume();

    // early termination request on the 2nd slice
    send(2'b11, 1'b0);
    send(2'b01, 1'b1);
    chk("last_dat_lsb", dat_a, 8'h07);
    chk("last_dat_msb", dat_b, 8'hD0);
`ifdef DEMUX_LAST_SLICE_EN
    chk("last_vld", {vld_a, vld_b}, 2'b11);
    chk("last_cnt", {cnt_a, cnt_b}, 4'h0);
`else
    chk("last_vld", {vld_a, vld_b}, 2'b00);
    chk("last_cnt", {cnt_a, cnt_b}, {2'd2, 2'd2});
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
